// File: rtl/counter_d_step_pkg.sv
// Shared widths and the extended-count type used for overflow-free bound compares.
package counter_d_step_pkg;

  localparam int CNT_WIDTH  = 36;
  localparam int STEP_WIDTH = 9;

  // One extra bit so cnt+step and MIN_COUNT+step never alias at full scale.
  typedef logic [CNT_WIDTH:0] ext_cnt_t;

endpackage

// File: rtl/counter_d_next.sv
// Combinational next-count for an enabled edge: step up/down with wrap onto the opposite bound.
module counter_d_next
  import counter_d_step_pkg::*;
#(
  parameter int WIDTH      = CNT_WIDTH,
  parameter int STEP_WIDTH = counter_d_step_pkg::STEP_WIDTH
) (
  input  logic [WIDTH-1:0]      cnt_i,
  input  logic                  updown_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0]      min_i,
  input  logic [WIDTH-1:0]      max_i,
  output logic [WIDTH-1:0]      cnt_d_o
);

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   min_ext;
  logic [WIDTH:0]   max_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   floor_ext;
  logic [WIDTH-1:0] diff;

  always_comb begin
    cnt_ext   = {1'b0, cnt_i};
    step_ext  = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, step_i};
    min_ext   = {1'b0, min_i};
    max_ext   = {1'b0, max_i};
    sum_ext   = cnt_ext + step_ext;
    floor_ext = min_ext + step_ext;
    diff      = cnt_i - step_ext[WIDTH-1:0];
  end

  // An out-of-range count falls into the same wrap branches, so no separate
  // correction path is needed; MIN > MAX is handled by the same literal rules.
  always_comb begin
    cnt_d_o = cnt_i;
    if (updown_i) begin
      if (sum_ext > max_ext) cnt_d_o = min_i;
      else                   cnt_d_o = sum_ext[WIDTH-1:0];
    end else begin
      if (cnt_ext < floor_ext) cnt_d_o = max_i;
      else                     cnt_d_o = diff;
    end
  end

endmodule

// File: rtl/counter_d_step.sv
// Programmable up/down step counter with run-time inclusive bounds; cnt is a bare register.
module counter_d_step
  import counter_d_step_pkg::*;
#(
  parameter int WIDTH      = CNT_WIDTH,
  parameter int STEP_WIDTH = counter_d_step_pkg::STEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  updown,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      MIN_COUNT,
  input  logic [WIDTH-1:0]      MAX_COUNT,
  output logic [WIDTH-1:0]      cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  counter_d_next #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_next (
    .cnt_i    (cnt_q),
    .updown_i (updown),
    .step_i   (step),
    .min_i    (MIN_COUNT),
    .max_i    (MAX_COUNT),
    .cnt_d_o  (cnt_d)
  );

  // ena is a plain per-cycle qualifier; there is no valid/ready handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt_q <= '0;
    else if (ena) cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_counter_d_step.sv
// Directed table-driven bench for counter_d_step plus hand-written reset sequences.
module tb_counter_d_step;

  localparam int W  = 36;
  localparam int SW = 9;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};
  localparam logic [W-1:0] TOP3 = {W{1'b1}} - 36'd2;

  typedef struct {
    logic          ena;
    logic          updown;
    logic [SW-1:0] step;
    logic [W-1:0]  min_c;
    logic [W-1:0]  max_c;
    logic [W-1:0]  exp;
    string         name;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          updown;
  logic [SW-1:0] step;
  logic [W-1:0]  min_c;
  logic [W-1:0]  max_c;
  logic [W-1:0]  cnt;

  vec_t vecs[$];
  int   tests_run;
  int   tests_failed;

  counter_d_step dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .updown    (updown),
    .step      (step),
    .MIN_COUNT (min_c),
    .MAX_COUNT (max_c),
    .cnt       (cnt)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Driver / checker tasks
  task automatic add_vec(input logic e, input logic ud, input logic [SW-1:0] s,
                         input logic [W-1:0] mn, input logic [W-1:0] mx,
                         input logic [W-1:0] ex, input string nm);
    vec_t v;
    v.ena = e; v.updown = ud; v.step = s; v.min_c = mn; v.max_c = mx; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic ud, input logic [SW-1:0] s,
                       input logic [W-1:0] mn, input logic [W-1:0] mx);
    @(negedge clk);
    ena = e; updown = ud; step = s; min_c = mn; max_c = mx;
  endtask

  task automatic edge_check(input string nm, input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    check(nm, cnt, exp);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0; ena = 1'b0; updown = 1'b1; step = '0; min_c = '0; max_c = '0;

    // Expected sequence, hand-computed; each row follows on from the previous one.
    add_vec(1, 1, 3, 2, 10, 3, "up_wrap_1");
    add_vec(1, 1, 3, 2, 10, 6, "up_wrap_2");
    add_vec(1, 1, 3, 2, 10, 9, "up_wrap_3");
    add_vec(1, 1, 3, 2, 10, 2, "up_wrap_4");
    add_vec(1, 1, 3, 2, 10, 5, "up_wrap_5");
    add_vec(1, 1, 3, 2, 10, 8, "up_wrap_6");
    add_vec(1, 1, 3, 2, 10, 2, "up_wrap_7");
    add_vec(1, 0, 4, 2, 10, 10, "down_to_max");
    add_vec(1, 0, 4, 2, 10, 6, "down_wrap_1");
    add_vec(1, 0, 4, 2, 10, 2, "down_wrap_2");
    add_vec(1, 0, 4, 2, 10, 10, "down_wrap_3");
    add_vec(1, 0, 4, 2, 10, 6, "down_wrap_4");
    add_vec(1, 0, 6, 0, 100, 0, "down_exact_min");
    add_vec(1, 1, 1, 0, 100, 1, "ena_1");
    add_vec(0, 1, 1, 0, 100, 1, "ena_0a");
    add_vec(0, 1, 1, 0, 100, 1, "ena_0b");
    add_vec(1, 1, 1, 0, 100, 2, "ena_1b");
    add_vec(1, 1, 3, 0, 100, 5, "to_five");
    add_vec(1, 1, 1, 0, 100, 6, "dir_up_1");
    add_vec(1, 1, 1, 0, 100, 7, "dir_up_2");
    add_vec(1, 0, 1, 0, 100, 6, "dir_dn_1");
    add_vec(1, 0, 1, 0, 100, 5, "dir_dn_2");
    add_vec(1, 0, 1, 0, 100, 4, "dir_dn_3");
    add_vec(1, 1, 0, 0, 100, 4, "step0_hold");
    add_vec(1, 1, 0, 0, 3, 0, "oor_above_max");
    add_vec(1, 0, 0, 5, 20, 20, "oor_below_min");
    add_vec(1, 1, 1, 10, 5, 10, "minmax_inv_up1");
    add_vec(1, 1, 1, 10, 5, 10, "minmax_inv_up2");
    add_vec(1, 0, 1, 10, 5, 5, "minmax_inv_dn1");
    add_vec(1, 0, 1, 10, 5, 5, "minmax_inv_dn2");
    add_vec(1, 0, 1, 100, TOP3, TOP3, "load_top3_a");
    add_vec(1, 1, 5, 0, ALL1, 0, "full_width_wrap5");
    add_vec(1, 0, 1, 100, TOP3, TOP3, "load_top3_b");
    add_vec(1, 1, 2, 0, ALL1, ALL1, "full_width_eq_max");
    add_vec(1, 1, 0, 0, ALL1, ALL1, "full_width_hold");
    add_vec(1, 1, 1, 0, ALL1, 0, "full_width_wrap1");
    add_vec(1, 0, 0, 0, 1000, 0, "down_step0_at_min");
    add_vec(1, 0, 511, 0, 1000, 1000, "down_maxstep_wrap");
    add_vec(1, 0, 511, 0, 1000, 489, "down_maxstep");
    add_vec(0, 1, 511, 0, 10, 489, "disabled_no_wrap");

    // Reset state
    #3;
    check("reset_state", cnt, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ena, vecs[i].updown, vecs[i].step, vecs[i].min_c, vecs[i].max_c);
      edge_check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset mid-count at 57, then hold in reset with ena high.
    drive(1, 1, 57, 0, 100);
    edge_check("to57_wrap", 0);
    edge_check("to57", 57);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_now", cnt, '0);
    for (int i = 0; i < 3; i++) edge_check("reset_hold", 0);

    // First update on the first rising edge after release.
    @(negedge clk);
    rst = 1'b1;
    edge_check("reset_release", 57);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_d_step.md
# counter_d_step

Programmable up/down step counter with run-time bounds, used by the Biplex FFT control path to generate addresses and sequence indices. On each enabled clock it advances a 36-bit count by a 9-bit step in the selected direction. It wraps between run-time `MIN_COUNT` and `MAX_COUNT` limits. The block is fully synchronous to one clock apart from its asynchronous reset.

## Interface
Parameters:
- `WIDTH`, 36, counter and bound width.
- `STEP_WIDTH`, 9, step input width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain.
- `ena`  in  1  count enable; when 0, `cnt` holds.
- `updown`  in  1  direction: 1 counts up, 0 counts down.
- `step`  in  STEP_WIDTH  unsigned increment or decrement magnitude.
- `MIN_COUNT`  in  WIDTH  unsigned lower bound, inclusive.
- `MAX_COUNT`  in  WIDTH  unsigned upper bound, inclusive.
- `cnt`  out  WIDTH  current count, driven directly from a register.

## Operation
- `rst`=0 forces `cnt` to 0 immediately, regardless of `clk`.
- With `rst`=1 and `ena`=0, `cnt` holds its value.
- With `ena`=1 and `updown`=1:
  - `cnt + step` is computed at WIDTH+1 bits, so there is no silent overflow.
  - If the sum is greater than `MAX_COUNT`, the next `cnt` is `MIN_COUNT`.
  - Otherwise the next `cnt` is the sum.
- With `ena`=1 and `updown`=0:
  - If `cnt < MIN_COUNT + step` (compared at WIDTH+1 bits), the next `cnt` is `MAX_COUNT`.
  - Otherwise the next `cnt` is `cnt - step`.
- `step`=0 with `ena`=1 holds the value, except that an out-of-range `cnt` is still corrected by the rules below.
- Out-of-range handling:
  - If `cnt` is already above `MAX_COUNT` while counting up, it goes to `MIN_COUNT` on the next enabled edge.
  - If `cnt` is below `MIN_COUNT` while counting down, it goes to `MAX_COUNT` on the next enabled edge.
- Wrap lands exactly on the opposite bound; the residual step is discarded.
- `MIN_COUNT`, `MAX_COUNT`, `step` and `updown` are sampled every enabled edge. Changing them mid-count takes effect on the next edge.
- `MIN_COUNT > MAX_COUNT` is a caller error. The required deterministic result is that the rules above are applied literally; no special casing.
- All arithmetic is unsigned.

## Timing
- Latency is one cycle: inputs sampled at edge k determine `cnt` after edge k.
- Reset assertion is asynchronous.
- Reset release is used synchronously: the first update happens on the first rising edge with `rst`=1.
- No handshake exists; `ena` is a per-cycle qualifier.
- Reset during counting discards the current count immediately.

## Structure
- A shared package holds `WIDTH`/`STEP_WIDTH` defaults and a WIDTH+1 extended-count type for the bound compares.
- Natural split: combinational next-value function (`counter_d_next`) plus a single register process in the top.
- No other sub-modules.

## Test plan
- Reset: `rst`=0 mid-count with `cnt`=57 → `cnt`=0 without a clock edge; holds at 0 while `rst`=0.
- Up wrap: MIN=2, MAX=10, step=3, updown=1, ena=1, starting from 0 → `cnt` sequence 3, 6, 9, 2, 5, 8, 2.
- Down wrap: MIN=2, MAX=10, step=4, updown=0, starting from 10 → 6, 2, 10, 6.
- Enable/hold: ena toggles 1,0,0,1 with step=1 from 0 → 1, 1, 1, 2.
- Full width: MIN=0, MAX=2^36−1, cnt=2^36−3, step=5 → `cnt`=0 (no overflow alias).
- Direction change mid-run: step=1 from 5, up for 2 cycles then down for 3 → 6, 7, 6, 5, 4.
